bcd_a_binario: RTL

Sequential BCD-to-binary converter using reverse double dabble (shift right, subtract 3). It converts a sign plus DIGITS decimal digits, entered by the user as a Booth-multiplier operand, into a two's-complement binary word for the multiplier datapath. It is the inverse of the display-side binary-to-BCD converter and uses the same inicio/done pulse handshake.

---
 rtl/bcd_pkg.sv | 20 ++
 rtl/bcd_a_binario_if.sv | 23 ++
 rtl/corrector_digito_bcd.sv | 9 +
 rtl/bcd_a_binario.sv | 130 +++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD <-> binary converters: state encoding and digit limits.
// Both directions import this so their FSMs stay encoded identically.
package bcd_pkg;

    typedef enum logic [2:0] {
        INACTIVO = 3'd0,
        SHIFT    = 3'd1,
        CORREGIR = 3'd2,
        SIGNO    = 3'd3,
        FINAL    = 3'd4
    } estado_t;

    localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
    localparam logic [3:0] CORR_UMBRAL   = 4'd8;

    function automatic logic digito_valido(input logic [3:0] d);
        return d <= BCD_DIGIT_MAX;
    endfunction

endpackage

// File: rtl/bcd_a_binario_if.sv
// Start/done handshake and data bus between the operand entry logic and the BCD-to-binary converter.
interface bcd_a_binario_if #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
);
    logic                  inicio;
    logic                  signo;
    logic [4*DIGITS-1:0]   bcd;
    logic [BIN_W:0]        binario;
    logic                  done;
    logic                  ocupado;
    logic                  error;

    modport master (
        output inicio, signo, bcd,
        input  binario, done, ocupado, error
    );

    modport slave (
        input  inicio, signo, bcd,
        output binario, done, ocupado, error
    );
endinterface

// File: rtl/corrector_digito_bcd.sv
// One-digit correction step of reverse double dabble: a nibble of 8 or more loses 3.
module corrector_digito_bcd
    import bcd_pkg::*;
(
    input  logic [3:0] d,
    output logic [3:0] q
);
    assign q = (d >= CORR_UMBRAL) ? d - 4'd3 : d;
endmodule

// File: rtl/bcd_a_binario.sv
// Sequential signed BCD-to-binary converter (reverse double dabble: shift right, subtract 3).
// Fixed latency of 8*DIGITS cycles for valid input, 2 cycles when a digit is out of range.
module bcd_a_binario
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic           clk,
    input  logic           reset,
    bcd_a_binario_if.slave bus
);
    localparam int REG_W = 4*DIGITS;
    localparam int CNT_W = (REG_W > 1) ? $clog2(REG_W) : 1;
    localparam logic [CNT_W-1:0] CNT_ULT = CNT_W'(REG_W-1);

    estado_t          estado, estado_sig;
    logic [REG_W-1:0] bcd_reg, bin_reg, bcd_corr;
    logic [CNT_W-1:0] cnt;
    logic             signo_reg;
    logic             entrada_invalida;
    logic             cargar, desplazar, corregir, escribir_res, escribir_err;

    function automatic logic hay_digito_invalido(input logic [REG_W-1:0] v);
        logic inv;
        inv = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!digito_valido(v[4*i +: 4]))
                inv = 1'b1;
        end
        return inv;
    endfunction

    // Negative zero falls out naturally: -0 is 0 in two's complement.
    function automatic logic signed [BIN_W:0] aplicar_signo(input logic neg,
                                                            input logic [BIN_W-1:0] mag_in);
        logic signed [BIN_W:0] mag;
        mag = signed'({1'b0, mag_in});
        return neg ? -mag : mag;
    endfunction

    assign entrada_invalida = hay_digito_invalido(bus.bcd);

    for (genvar g = 0; g < DIGITS; g++) begin : g_corr
        corrector_digito_bcd u_corr (
            .d (bcd_reg[4*g +: 4]),
            .q (bcd_corr[4*g +: 4])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            estado <= INACTIVO;
        else
            estado <= estado_sig;
    end

    always_comb begin
        estado_sig   = estado;
        cargar       = 1'b0;
        desplazar    = 1'b0;
        corregir     = 1'b0;
        escribir_res = 1'b0;
        escribir_err = 1'b0;
        case (estado)
            INACTIVO: begin
                if (bus.inicio) begin
                    cargar     = 1'b1;
                    estado_sig = entrada_invalida ? FINAL : SHIFT;
                end
            end
            SHIFT: begin
                desplazar  = 1'b1;
                estado_sig = (cnt == CNT_ULT) ? SIGNO : CORREGIR;
            end
            CORREGIR: begin
                corregir   = 1'b1;
                estado_sig = SHIFT;
            end
            SIGNO: begin
                escribir_res = 1'b1;
                estado_sig   = INACTIVO;
            end
            FINAL: begin
                escribir_err = 1'b1;
                estado_sig   = INACTIVO;
            end
            default: estado_sig = INACTIVO;
        endcase
    end

    // Working register {bcd_reg, bin_reg} shifts as one word; no correction follows the last shift.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bcd_reg     <= '0;
            bin_reg     <= '0;
            cnt         <= '0;
            signo_reg   <= 1'b0;
            bus.binario <= '0;
            bus.done    <= 1'b0;
            bus.ocupado <= 1'b0;
            bus.error   <= 1'b0;
        end else begin
            bus.done <= escribir_res | escribir_err;
            if (cargar) begin
                bcd_reg     <= bus.bcd;
                bin_reg     <= '0;
                cnt         <= '0;
                signo_reg   <= bus.signo;
                bus.error   <= entrada_invalida;
                bus.ocupado <= 1'b1;
            end
            if (desplazar) begin
                {bcd_reg, bin_reg} <= {1'b0, bcd_reg, bin_reg[REG_W-1:1]};
                cnt <= (cnt == CNT_ULT) ? '0 : cnt + 1'b1;
            end
            if (corregir)
                bcd_reg <= bcd_corr;
            if (escribir_res) begin
                bus.binario <= aplicar_signo(signo_reg, bin_reg[BIN_W-1:0]);
                bus.ocupado <= 1'b0;
            end
            if (escribir_err) begin
                bus.binario <= '0;
                bus.ocupado <= 1'b0;
            end
        end
    end

endmodule
